// File: rtl/ttio_icb_ctrl.sv
// TTIO ICB bridge: buffers TTIO commands, tracks outstanding LSU-ctrl transactions
// and returns every response as an aligned, extended long-pipe write-back beat.
module ttio_icb_ctrl #(
  parameter int CMD_DEPTH  = 2,
  parameter int OUTS_DEPTH = 2,
  parameter int AW         = 32,
  parameter int XW         = 32,
  parameter int ITAG_W     = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ttio_icb_cmd_valid,
  output logic              ttio_icb_cmd_ready,
  input  logic [AW-1:0]     ttio_icb_cmd_addr,
  input  logic              ttio_icb_cmd_read,
  input  logic [XW-1:0]     ttio_icb_cmd_wdata,
  input  logic [XW/8-1:0]   ttio_icb_cmd_wmask,
  input  logic [1:0]        ttio_icb_cmd_size,
  input  logic              ttio_icb_cmd_usign,
  input  logic [ITAG_W-1:0] ttio_icb_cmd_itag,

  output logic              lsu_icb_cmd_valid,
  input  logic              lsu_icb_cmd_ready,
  output logic [AW-1:0]     lsu_icb_cmd_addr,
  output logic              lsu_icb_cmd_read,
  output logic [XW-1:0]     lsu_icb_cmd_wdata,
  output logic [XW/8-1:0]   lsu_icb_cmd_wmask,
  output logic [1:0]        lsu_icb_cmd_size,

  input  logic              lsu_icb_rsp_valid,
  output logic              lsu_icb_rsp_ready,
  input  logic              lsu_icb_rsp_err,
  input  logic [XW-1:0]     lsu_icb_rsp_rdata,

  output logic              lwbck_valid,
  input  logic              lwbck_ready,
  output logic [XW-1:0]     lwbck_wdat,
  output logic              lwbck_err,
  output logic [ITAG_W-1:0] lwbck_itag,

  output logic              ctrl_busy,
  output logic              prot_err
);

  // Pointers carry one extra wrap bit; slot index widths never drop below 1.
  localparam int CPW = $clog2(CMD_DEPTH) + 1;
  localparam int CIW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int OPW = $clog2(OUTS_DEPTH) + 1;
  localparam int OIW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  logic [AW-1:0]     cmd_addr_q  [1<<CIW];
  logic              cmd_read_q  [1<<CIW];
  logic [XW-1:0]     cmd_wdata_q [1<<CIW];
  logic [XW/8-1:0]   cmd_wmask_q [1<<CIW];
  logic [1:0]        cmd_size_q  [1<<CIW];
  logic              cmd_usign_q [1<<CIW];
  logic [ITAG_W-1:0] cmd_itag_q  [1<<CIW];

  logic [CPW-1:0] cmd_wptr, cmd_rptr;
  logic [CIW-1:0] cmd_widx, cmd_ridx;
  logic           cmd_empty, cmd_full, cmd_push, cmd_pop;

  logic [ITAG_W-1:0] outs_itag_q  [1<<OIW];
  logic              outs_read_q  [1<<OIW];
  logic [1:0]        outs_lo_q    [1<<OIW];
  logic [1:0]        outs_size_q  [1<<OIW];
  logic              outs_usign_q [1<<OIW];

  logic [OPW-1:0] outs_wptr, outs_rptr;
  logic [OIW-1:0] outs_widx, outs_ridx;
  logic           outs_empty, outs_full, outs_push, outs_pop;

  logic [ITAG_W-1:0] head_itag;
  logic              head_read, head_usign;
  logic [1:0]        head_lo, head_size;
  logic [XW-1:0]     rsp_sh, load_data;
  logic              ext_bit;

  // A wrap-bit pointer difference equal to the depth is the same as
  // "MSBs differ, remaining bits equal", and also covers a depth of 1.
  assign cmd_empty = (cmd_wptr == cmd_rptr);
  assign cmd_full  = ((cmd_wptr - cmd_rptr) == CPW'(CMD_DEPTH));
  assign cmd_widx  = CIW'(cmd_wptr);
  assign cmd_ridx  = CIW'(cmd_rptr);

  assign outs_empty = (outs_wptr == outs_rptr);
  assign outs_full  = ((outs_wptr - outs_rptr) == OPW'(OUTS_DEPTH));
  assign outs_widx  = OIW'(outs_wptr);
  assign outs_ridx  = OIW'(outs_rptr);

  assign ttio_icb_cmd_ready = ~cmd_full;
  assign cmd_push           = ttio_icb_cmd_valid & ttio_icb_cmd_ready;

  assign lsu_icb_cmd_valid = ~cmd_empty & ~outs_full;
  assign lsu_icb_cmd_addr  = cmd_addr_q[cmd_ridx];
  assign lsu_icb_cmd_read  = cmd_read_q[cmd_ridx];
  assign lsu_icb_cmd_wdata = cmd_wdata_q[cmd_ridx];
  assign lsu_icb_cmd_wmask = cmd_wmask_q[cmd_ridx];
  assign lsu_icb_cmd_size  = cmd_size_q[cmd_ridx];
  assign cmd_pop           = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
  assign outs_push         = cmd_pop;

  assign lwbck_valid       = lsu_icb_rsp_valid & ~outs_empty;
  assign lsu_icb_rsp_ready = lwbck_ready | outs_empty;
  assign outs_pop          = lsu_icb_rsp_valid & lwbck_ready & ~outs_empty;

  assign ctrl_busy = ~cmd_empty | ~outs_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wptr <= '0;
      cmd_rptr <= '0;
    end else begin
      if (cmd_push) cmd_wptr <= cmd_wptr + CPW'(1);
      if (cmd_pop)  cmd_rptr <= cmd_rptr + CPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_addr_q[cmd_widx]  <= ttio_icb_cmd_addr;
      cmd_read_q[cmd_widx]  <= ttio_icb_cmd_read;
      cmd_wdata_q[cmd_widx] <= ttio_icb_cmd_wdata;
      cmd_wmask_q[cmd_widx] <= ttio_icb_cmd_wmask;
      cmd_size_q[cmd_widx]  <= ttio_icb_cmd_size;
      cmd_usign_q[cmd_widx] <= ttio_icb_cmd_usign;
      cmd_itag_q[cmd_widx]  <= ttio_icb_cmd_itag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_wptr <= '0;
      outs_rptr <= '0;
    end else begin
      if (outs_push) outs_wptr <= outs_wptr + OPW'(1);
      if (outs_pop)  outs_rptr <= outs_rptr + OPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (outs_push) begin
      outs_itag_q[outs_widx]  <= cmd_itag_q[cmd_ridx];
      outs_read_q[outs_widx]  <= cmd_read_q[cmd_ridx];
      outs_lo_q[outs_widx]    <= cmd_addr_q[cmd_ridx][1:0];
      outs_size_q[outs_widx]  <= cmd_size_q[cmd_ridx];
      outs_usign_q[outs_widx] <= cmd_usign_q[cmd_ridx];
    end
  end

  assign head_itag  = outs_itag_q[outs_ridx];
  assign head_read  = outs_read_q[outs_ridx];
  assign head_lo    = outs_lo_q[outs_ridx];
  assign head_size  = outs_size_q[outs_ridx];
  assign head_usign = outs_usign_q[outs_ridx];

  // Shift the addressed byte lane down to bit 0, then extend to the access size.
  always_comb begin
    rsp_sh    = lsu_icb_rsp_rdata >> {head_lo, 3'b000};
    ext_bit   = 1'b0;
    load_data = rsp_sh;
    case (head_size)
      2'b00: begin
        ext_bit   = ~head_usign & rsp_sh[7];
        load_data = {{(XW-8){ext_bit}}, rsp_sh[7:0]};
      end
      2'b01: begin
        ext_bit   = ~head_usign & rsp_sh[15];
        load_data = {{(XW-16){ext_bit}}, rsp_sh[15:0]};
      end
      default: load_data = rsp_sh;
    endcase
  end

  assign lwbck_wdat = head_read ? load_data : '0;
  assign lwbck_err  = lsu_icb_rsp_err;
  assign lwbck_itag = head_itag;

  // A response with nothing outstanding is accepted and dropped; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prot_err <= 1'b0;
    end else if (lsu_icb_rsp_valid & outs_empty) begin
      prot_err <= 1'b1;
    end
  end

endmodule
